// File: rtl/jtgng_vidgen.sv
// 15 kHz arcade video timing generator with a selectable test pattern.
// Every output is registered from the next {H,V} pair so colour and blanking share the same pixel.
module jtgng_vidgen #(
  parameter int COLORW   = 4,
  parameter int HTOTAL   = 384,
  parameter int HACTIVE  = 256,
  parameter int HS_START = 288,
  parameter int HS_LEN   = 32,
  parameter int VTOTAL   = 262,
  parameter int VB_END   = 16,
  parameter int VB_START = 240,
  parameter int VS_START = 248,
  parameter int VS_LEN   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cen_i,
  input  logic [1:0]        pattern_sel_i,
  output logic [8:0]        h_o,
  output logic [8:0]        v_o,
  output logic              lhbl_o,
  output logic              lvbl_o,
  output logic              hs_o,
  output logic              vs_o,
  output logic [COLORW-1:0] red_o,
  output logic [COLORW-1:0] green_o,
  output logic [COLORW-1:0] blue_o,
  output logic              frame_o
);

  typedef enum logic [1:0] {PAT_BARS, PAT_GRID, PAT_GRAD, PAT_BLACK} pat_t;

  localparam logic [8:0] H_LAST  = 9'(HTOTAL - 1);
  localparam logic [8:0] V_LAST  = 9'(VTOTAL - 1);
  localparam logic [8:0] H_ACT   = 9'(HACTIVE);
  localparam logic [8:0] H_EDGE  = 9'(HACTIVE - 1);
  localparam logic [8:0] HS_BEG  = 9'(HS_START);
  localparam logic [9:0] HS_END  = 10'(HS_START + HS_LEN);
  localparam logic [8:0] VB_BEG  = 9'(VB_END);
  localparam logic [8:0] VB_STOP = 9'(VB_START);
  localparam logic [8:0] V_EDGE  = 9'(VB_START - 1);
  localparam logic [8:0] VS_BEG  = 9'(VS_START);
  localparam logic [9:0] VS_END  = 10'(VS_START + VS_LEN);
  localparam logic [7:0] VB_OFS  = 8'(VB_END);
  localparam logic [COLORW-1:0] CMAX = {COLORW{1'b1}};

  logic [8:0]        h_q, v_q, h_d, v_d;
  logic              lhbl_q, lvbl_q, hs_q, vs_q, frame_q;
  logic              lhbl_d, lvbl_d, hs_d, vs_d, frame_d;
  logic [COLORW-1:0] red_q, green_q, blue_q, red_d, green_d, blue_d;
  pat_t              pat_q, pat_d;
  logic              h_wrap, frame_start, grid_on;
  logic [7:0]        vrel;
  logic [2:0]        bar;

  always_comb begin
    h_wrap      = (h_q == H_LAST);
    frame_start = h_wrap && (v_q == V_LAST);
    h_d         = h_wrap ? 9'd0 : h_q + 9'd1;
    v_d         = v_q;
    if (h_wrap) v_d = (v_q == V_LAST) ? 9'd0 : v_q + 9'd1;
    frame_d     = frame_start ? ~frame_q : frame_q;
    // The pattern only switches on the frame boundary to avoid tearing.
    pat_d       = frame_start ? pat_t'(pattern_sel_i) : pat_q;

    lhbl_d = (h_d < H_ACT);
    lvbl_d = (v_d >= VB_BEG) && (v_d < VB_STOP);
    hs_d   = !((h_d >= HS_BEG) && ({1'b0, h_d} < HS_END));
    // VS edges are aligned with the HS falling edge.
    vs_d   = vs_q;
    if (h_d == HS_BEG) vs_d = !((v_d >= VS_BEG) && ({1'b0, v_d} < VS_END));

    vrel    = v_d[7:0] - VB_OFS;
    bar     = h_d[7:5];
    grid_on = (h_d[3:0] == 4'd0) || (vrel[3:0] == 4'd0) ||
              (h_d == H_EDGE) || (v_d == V_EDGE);
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    if (lhbl_d && lvbl_d) begin
      case (pat_d)
        PAT_BARS: begin
          red_d   = {COLORW{bar[2]}};
          green_d = {COLORW{bar[1]}};
          blue_d  = {COLORW{bar[0]}};
        end
        PAT_GRID: begin
          red_d   = grid_on ? CMAX : '0;
          green_d = grid_on ? CMAX : '0;
          blue_d  = grid_on ? CMAX : '0;
        end
        PAT_GRAD: begin
          red_d   = h_d[7 -: COLORW];
          green_d = vrel[7 -: COLORW];
          blue_d  = CMAX - h_d[7 -: COLORW];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q     <= '0;
      v_q     <= '0;
      lhbl_q  <= 1'b1;
      lvbl_q  <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      frame_q <= 1'b0;
      pat_q   <= PAT_BARS;
    end else if (cen_i) begin
      h_q     <= h_d;
      v_q     <= v_d;
      lhbl_q  <= lhbl_d;
      lvbl_q  <= lvbl_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
      frame_q <= frame_d;
      pat_q   <= pat_d;
    end
  end

  assign h_o     = h_q;
  assign v_o     = v_q;
  assign lhbl_o  = lhbl_q;
  assign lvbl_o  = lvbl_q;
  assign hs_o    = hs_q;
  assign vs_o    = vs_q;
  assign red_o   = red_q;
  assign green_o = green_q;
  assign blue_o  = blue_q;
  assign frame_o = frame_q;

endmodule
